// File: rtl/cmvn_denorm.sv
// rtl/cmvn_denorm.sv - inverse CMVN stage: out = sat32(((in * std) >>> FRAC) + mean), 2-stage stream
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   cfg_we/sel/addr/data  table write port (sel 0 = mean, 1 = std), out-of-range addresses ignored
//   in_valid/ready/data/addr   normalized Q1.7.24 sample stream with bin index
//   out_valid/ready/data/addr  de-normalized Q1.7.24 sample stream with bin index
//   frame_done            one-cycle pulse after every NUM_BINS-th output transfer
//   err_addr              sticky: a sample with address >= NUM_BINS was accepted
module cmvn_denorm #(
  parameter int NUM_BINS = 20,
  parameter int FRAC     = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_we,
  input  logic        cfg_sel,
  input  logic [4:0]  cfg_addr,
  input  logic [31:0] cfg_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [4:0]  in_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_addr,
  output logic        frame_done,
  output logic        err_addr
);

  localparam logic [4:0]         LAST_BIN = 5'(NUM_BINS - 1);
  localparam logic signed [63:0] SAT_MAX  = 64'sh0000_0000_7FFF_FFFF;
  localparam logic signed [63:0] SAT_MIN  = 64'shFFFF_FFFF_8000_0000;

  // Tables are deliberately outside the reset domain: firmware loads them once.
  logic signed [31:0] mean_q [NUM_BINS];
  logic signed [31:0] std_q  [NUM_BINS];

  logic               s1_valid_q;
  logic signed [63:0] s1_prod_q;
  logic signed [31:0] s1_mean_q;
  logic [4:0]         s1_addr_q;

  logic               out_valid_q;
  logic [31:0]        out_data_q;
  logic [4:0]         out_addr_q;
  logic [4:0]         cnt_q, cnt_d;
  logic               frame_done_q, frame_done_d;
  logic               err_addr_q;

  logic               in_addr_ok, cfg_hit;
  logic               out_free, in_fire, s2_load, out_fire;
  logic signed [31:0] std_rd, mean_rd;
  logic signed [63:0] in_ext, std_ext, prod_d;
  logic signed [63:0] prod_sh, mean_ext, sum_d;
  logic [31:0]        out_data_d;

  assign cfg_hit    = cfg_we && (cfg_addr <= LAST_BIN);
  assign in_addr_ok = (in_addr <= LAST_BIN);

  assign out_free = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || out_free;
  assign in_fire  = in_valid && in_ready;
  assign s2_load  = s1_valid_q && out_free;
  assign out_fire = out_valid_q && out_ready;

  // Writes land at the edge; the stage-1 read below sees the pre-write value.
  always_ff @(posedge clk) begin
    if (cfg_hit) begin
      if (cfg_sel) std_q[cfg_addr]  <= cfg_data;
      else         mean_q[cfg_addr] <= cfg_data;
    end
  end

  // Stage 1: table read and full-width signed product.
  always_comb begin
    std_rd  = '0;
    mean_rd = '0;
    if (in_addr_ok) begin
      std_rd  = std_q[in_addr];
      mean_rd = mean_q[in_addr];
    end
    in_ext  = {{32{in_data[31]}}, in_data};
    std_ext = {{32{std_rd[31]}}, std_rd};
    prod_d  = in_ext * std_ext;
  end

  // Stage 2: rescale, add mean, clamp. Shift is done in its own signed
  // variable so it stays arithmetic regardless of the surrounding expression.
  always_comb begin
    prod_sh  = s1_prod_q >>> FRAC;
    mean_ext = {{32{s1_mean_q[31]}}, s1_mean_q};
    sum_d    = prod_sh + mean_ext;
    if (sum_d > SAT_MAX)      out_data_d = 32'h7FFF_FFFF;
    else if (sum_d < SAT_MIN) out_data_d = 32'h8000_0000;
    else                      out_data_d = sum_d[31:0];
  end

  // Frame tracking counts output transfers, not bin indices.
  always_comb begin
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    if (out_fire) begin
      if (cnt_q == LAST_BIN) begin
        cnt_d        = '0;
        frame_done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_prod_q    <= '0;
      s1_mean_q    <= '0;
      s1_addr_q    <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_addr_q   <= '0;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
      err_addr_q   <= 1'b0;
    end else begin
      if (in_fire) begin
        s1_valid_q <= 1'b1;
        s1_prod_q  <= prod_d;
        s1_mean_q  <= mean_rd;
        s1_addr_q  <= in_addr;
      end else if (s2_load) begin
        s1_valid_q <= 1'b0;
      end

      // A load while the old output is being taken keeps full throughput.
      if (s2_load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= out_data_d;
        out_addr_q  <= s1_addr_q;
      end else if (out_fire) begin
        out_valid_q <= 1'b0;
      end

      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
      if (in_fire && !in_addr_ok) err_addr_q <= 1'b1;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_addr   = out_addr_q;
  assign frame_done = frame_done_q;
  assign err_addr   = err_addr_q;

endmodule

// File: tb/tb_cmvn_denorm.sv
// tb/tb_cmvn_denorm.sv - scoreboard bench for cmvn_denorm with a table-based reference model
module tb_cmvn_denorm;

  localparam int NB = 20;
  localparam longint QMAX = 64'sd2147483647;
  localparam longint QMIN = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we, cfg_sel;
  logic [4:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_addr;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_addr;
  logic        frame_done, err_addr;

  logic        bp_mode = 1'b0;
  logic        ready_force = 1'b1;
  logic        rnd_q = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;
  int acc_cnt = 0;
  int fd_pulses = 0;

  longint      mean_m [NB];
  longint      std_m  [NB];
  logic [31:0] exp_d [$];
  logic [4:0]  exp_a [$];
  logic [31:0] out_log [$];
  int          tr_cnt = 0;
  logic        exp_fd = 1'b0;
  logic        exp_err = 1'b0;

  always #5 clk = ~clk;

  assign out_ready = bp_mode ? rnd_q : ready_force;

  always @(posedge clk) begin
    #1;
    rnd_q = ($urandom_range(0, 3) != 0);
  end

  cmvn_denorm dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
    .frame_done(frame_done), .err_addr(err_addr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: real-number semantics of y = x*s + m, floored to the Q.24 grid and clamped.
  function automatic logic [31:0] ref_out(input logic [31:0] din, input logic [4:0] a);
    longint p, s;
    if (a >= NB) return 32'h0;
    p = longint'($signed(din)) * std_m[a];
    s = (p >>> 24) + mean_m[a];
    if (s > QMAX) s = QMAX;
    if (s < QMIN) s = QMIN;
    return s[31:0];
  endfunction

  // Monitor + scoreboard: samples half a cycle away from the active edge.
  always @(negedge clk) begin
    logic [31:0] ed;
    logic [4:0]  ea;
    if (!rst_n) begin
      exp_d.delete();
      exp_a.delete();
      tr_cnt  = 0;
      exp_fd  = 1'b0;
      exp_err = 1'b0;
    end else begin
      chk("frame_done", {31'b0, frame_done}, {31'b0, exp_fd});
      chk("err_addr", {31'b0, err_addr}, {31'b0, exp_err});
      if (frame_done) fd_pulses++;
      exp_fd = 1'b0;
      if (out_valid && out_ready) begin
        out_log.push_back(out_data);
        if (exp_d.size() == 0) begin
          chk("unexpected_output", 32'h1, 32'h0);
        end else begin
          ed = exp_d.pop_front();
          ea = exp_a.pop_front();
          chk("out_data", out_data, ed);
          chk("out_addr", {27'b0, out_addr}, {27'b0, ea});
        end
        tr_cnt++;
        if (tr_cnt == NB) begin
          tr_cnt = 0;
          exp_fd = 1'b1;
        end
      end
      if (in_valid && in_ready) begin
        exp_d.push_back(ref_out(in_data, in_addr));
        exp_a.push_back(in_addr);
        acc_cnt++;
        if (in_addr >= NB) exp_err = 1'b1;
      end
    end
    // Tables ignore reset, so the model tracks writes unconditionally (after the read).
    if (cfg_we && cfg_addr < NB) begin
      if (cfg_sel) std_m[cfg_addr]  = longint'($signed(cfg_data));
      else         mean_m[cfg_addr] = longint'($signed(cfg_data));
    end
  end

  task automatic send(input logic [4:0] a, input logic [31:0] d);
    int k;
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!in_ready && k < 300);
    if (!in_ready) chk("send_timeout", 32'h1, 32'h0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic cfg_write(input logic sel, input logic [4:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = a; cfg_data = d;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_d.size() != 0 && k < 1000) begin
      @(posedge clk);
      k++;
    end
    chk("drain_left", 32'(exp_d.size()), 32'h0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int fd0, a0;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0;
    in_valid = 1'b0; in_data = '0; in_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_addr", {27'b0, out_addr}, 32'h0);
    @(posedge clk);
    #1;

    // Identity tables, latency, then one full frame.
    for (int k = 0; k < NB; k++) begin
      cfg_write(1'b1, 5'(k), 32'h0100_0000);
      cfg_write(1'b0, 5'(k), 32'h0);
    end
    send(5'd0, 32'h0100_0000);
    @(negedge clk);
    chk("lat_not_yet", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    chk("lat_valid", {31'b0, out_valid}, 32'h1);
    drain();
    do_reset();
    fd0 = fd_pulses;
    for (int k = 0; k < NB; k++) send(5'(k), 32'h0100_0000);
    drain();
    chk("ident_frames", 32'(fd_pulses - fd0), 32'h1);

    // Scale and offset.
    cfg_write(1'b1, 5'd3, 32'h0200_0000);
    cfg_write(1'b0, 5'd3, 32'd283695040);
    send(5'd3, 32'd16777216);
    send(5'd3, 32'hFF00_0000);
    drain();
    chk("scale_pos", out_log[out_log.size() - 2], 32'd317249472);

    // Saturation at both rails.
    cfg_write(1'b1, 5'd0, 32'h7FFF_FFFF);
    cfg_write(1'b0, 5'd0, 32'h7FFF_FFFF);
    send(5'd0, 32'h7FFF_FFFF);
    drain();
    chk("sat_hi", out_log[out_log.size() - 1], 32'h7FFF_FFFF);
    cfg_write(1'b0, 5'd0, 32'h8000_0000);
    send(5'd0, 32'h8000_0000);
    drain();
    chk("sat_lo", out_log[out_log.size() - 1], 32'h8000_0000);

    // Backpressure on a full frame.
    do_reset();
    fd0 = fd_pulses;
    a0  = acc_cnt;
    ready_force = 1'b0;
    fork
      begin
        for (int k = 0; k < NB; k++) send(5'(k), $urandom);
      end
      begin
        repeat (10) @(negedge clk);
        chk("bp_accepted", 32'(acc_cnt - a0), 32'h2);
        chk("bp_in_ready", {31'b0, in_ready}, 32'h0);
        chk("bp_out_valid", {31'b0, out_valid}, 32'h1);
        chk("bp_out_held", out_data, exp_d[0]);
        @(posedge clk);
        #1;
        ready_force = 1'b1;
      end
    join
    drain();
    chk("bp_frames", 32'(fd_pulses - fd0), 32'h1);
    chk("bp_count", 32'(acc_cnt - a0), 32'(NB));

    // Bad address, then a cfg write racing an accept on the same entry.
    send(5'd25, $urandom);
    drain();
    chk("bad_err_set", {31'b0, err_addr}, 32'h1);
    cfg_write(1'b1, 5'd5, 32'h0100_0000);
    cfg_write(1'b0, 5'd5, 32'h0);
    cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = 5'd5; cfg_data = 32'h0300_0000;
    send(5'd5, 32'h0100_0000);
    cfg_we = 1'b0;
    send(5'd5, 32'h0100_0000);
    drain();
    chk("race_old", out_log[out_log.size() - 2], 32'h0100_0000);
    chk("race_new", out_log[out_log.size() - 1], 32'h0300_0000);
    chk("bad_err_sticky", {31'b0, err_addr}, 32'h1);

    // Reset mid-frame with two samples in flight.
    do_reset();
    for (int k = 0; k < 6; k++) send(5'(k), $urandom);
    send(5'd30, $urandom);
    drain();
    ready_force = 1'b0;
    send(5'd7, $urandom);
    send(5'd8, $urandom);
    @(negedge clk);
    chk("mid_inflight", {31'b0, out_valid}, 32'h1);
    @(posedge clk);
    #1;
    do_reset();
    @(negedge clk);
    chk("mid_out_valid", {31'b0, out_valid}, 32'h0);
    chk("mid_frame_done", {31'b0, frame_done}, 32'h0);
    chk("mid_err_addr", {31'b0, err_addr}, 32'h0);
    chk("mid_in_ready", {31'b0, in_ready}, 32'h1);
    @(posedge clk);
    #1;
    ready_force = 1'b1;
    fd0 = fd_pulses;
    for (int k = 0; k < NB; k++) send(5'(k), $urandom);
    drain();
    chk("mid_frames", 32'(fd_pulses - fd0), 32'h1);

    // Random tables, data, addresses and output stalls.
    for (int k = 0; k < NB; k++) begin
      cfg_write(1'b1, 5'(k), $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 32'h0400_0000)));
      cfg_write(1'b0, 5'(k), $urandom);
    end
    bp_mode = 1'b1;
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        cfg_we = 1'b1; cfg_sel = 1'($urandom_range(0, 1));
        cfg_addr = 5'($urandom_range(0, 23)); cfg_data = $urandom;
      end
      send(($urandom_range(0, 15) == 0) ? 5'($urandom_range(20, 31)) : 5'($urandom_range(0, 19)),
           $urandom);
      cfg_we = 1'b0;
    end
    bp_mode = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
